// File: rtl/axis_bdim_packer.sv
// axis_bdim_packer: gathers BDIM consecutive ELEM_WIDTH-bit stream elements
// into one packed block word (element 0 in the LSBs) and emits it on a wide
// AXI-Stream, flagging tlast on the final block of every NUM_BLOCKS-block frame.
// Optional build macro BDIM_PACKER_PERF_EN adds transfer/stall counters.
module axis_bdim_packer #(
    parameter int ELEM_WIDTH = 8,
    parameter int BDIM       = 8,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [ELEM_WIDTH-1:0]      s_axis_input0_tdata,
    input  logic                       s_axis_input0_tvalid,
    output logic                       s_axis_input0_tready,
    output logic [BDIM*ELEM_WIDTH-1:0] m_axis_output0_tdata,
    output logic                       m_axis_output0_tvalid,
    input  logic                       m_axis_output0_tready,
`ifdef BDIM_PACKER_PERF_EN
    output logic [31:0]                perf_blocks_out,
    output logic [31:0]                perf_stall_cycles,
`endif
    output logic                       m_axis_output0_tlast
);

    localparam int CW = (BDIM > 1) ? $clog2(BDIM) : 1;
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int DW = BDIM * ELEM_WIDTH;

    // Reject illegal geometries before anything is built.
    if (BDIM < 1 || NUM_BLOCKS < 1) begin : g_param_check
        $fatal(1, "axis_bdim_packer: BDIM and NUM_BLOCKS must both be >= 1");
    end

    logic [CW-1:0] elem_cnt_r;
    logic [BW-1:0] blk_cnt_r;
    logic [DW-1:0] buf_r;
    logic [DW-1:0] m_tdata_r;
    logic          m_tvalid_r;
    logic          m_tlast_r;

    logic          last_elem_s;
    logic          s_tready_s;
    logic          accept_s;
    logic          load_s;
    logic          drain_s;
    logic          last_blk_s;
    logic [DW-1:0] packed_s;

    // Handshake decode: the final slot of a block may only be taken when the
    // output register is free or being emptied in the same cycle.
    always_comb begin
        last_elem_s = (elem_cnt_r == CW'(BDIM - 1));
        last_blk_s  = (blk_cnt_r == BW'(NUM_BLOCKS - 1));
        if (last_elem_s) begin
            s_tready_s = !m_tvalid_r || m_axis_output0_tready;
        end else begin
            s_tready_s = 1'b1;
        end
        accept_s = s_axis_input0_tvalid && s_tready_s;
        load_s   = accept_s && last_elem_s;
        drain_s  = m_tvalid_r && m_axis_output0_tready;
    end

    // Assemble the outgoing block: buffered elements plus the one arriving now
    // in the top slot (the buffer's own top slot is never written).
    always_comb begin
        packed_s = buf_r;
        packed_s[(BDIM-1)*ELEM_WIDTH +: ELEM_WIDTH] = s_axis_input0_tdata;
    end

    // Element position counter and partial-block buffer.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            elem_cnt_r <= '0;
            buf_r      <= '0;
        end else if (accept_s) begin
            if (last_elem_s) begin
                elem_cnt_r <= '0;
            end else begin
                elem_cnt_r <= elem_cnt_r + CW'(1);
            end
            for (int k = 0; k < BDIM - 1; k++) begin
                if (elem_cnt_r == CW'(k)) begin
                    buf_r[k*ELEM_WIDTH +: ELEM_WIDTH] <= s_axis_input0_tdata;
                end
            end
        end
    end

    // Output register and frame position: a load always wins over a drain so
    // back-to-back blocks leave without a bubble.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            m_tdata_r  <= '0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            blk_cnt_r  <= '0;
        end else if (load_s) begin
            m_tdata_r  <= packed_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= last_blk_s;
            if (last_blk_s) begin
                blk_cnt_r <= '0;
            end else begin
                blk_cnt_r <= blk_cnt_r + BW'(1);
            end
        end else if (drain_s) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign s_axis_input0_tready  = s_tready_s;
    assign m_axis_output0_tdata  = m_tdata_r;
    assign m_axis_output0_tvalid = m_tvalid_r;
    assign m_axis_output0_tlast  = m_tlast_r;

`ifdef BDIM_PACKER_PERF_EN
    logic [31:0] perf_blocks_r;
    logic [31:0] perf_stall_r;

    // Saturating counters of completed output transfers and stalled cycles.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            perf_blocks_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else begin
            if (drain_s && (perf_blocks_r != 32'hFFFF_FFFF)) begin
                perf_blocks_r <= perf_blocks_r + 32'd1;
            end
            if (m_tvalid_r && !m_axis_output0_tready && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_blocks_out   = perf_blocks_r;
    assign perf_stall_cycles = perf_stall_r;
`endif

endmodule

// File: tb/tb_axis_bdim_packer.sv
// Directed bench for axis_bdim_packer: one instance with BDIM=4/NUM_BLOCKS=2
// and one with BDIM=1/NUM_BLOCKS=3, sharing clock and reset.
module tb_axis_bdim_packer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  a_s_tdata;
    logic        a_s_tvalid;
    logic        a_s_tready;
    logic [31:0] a_m_tdata;
    logic        a_m_tvalid;
    logic        a_m_tready;
    logic        a_m_tlast;

    logic [7:0]  b_s_tdata;
    logic        b_s_tvalid;
    logic        b_s_tready;
    logic [7:0]  b_m_tdata;
    logic        b_m_tvalid;
    logic        b_m_tready;
    logic        b_m_tlast;

`ifdef BDIM_PACKER_PERF_EN
    logic [31:0] a_perf_blocks;
    logic [31:0] a_perf_stall;
    logic [31:0] b_perf_blocks;
    logic [31:0] b_perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_bdim_packer #(.ELEM_WIDTH(8), .BDIM(4), .NUM_BLOCKS(2)) dut (
        .ap_clk                (clk),
        .ap_rst_n              (rst_n),
        .s_axis_input0_tdata   (a_s_tdata),
        .s_axis_input0_tvalid  (a_s_tvalid),
        .s_axis_input0_tready  (a_s_tready),
        .m_axis_output0_tdata  (a_m_tdata),
        .m_axis_output0_tvalid (a_m_tvalid),
        .m_axis_output0_tready (a_m_tready),
`ifdef BDIM_PACKER_PERF_EN
        .perf_blocks_out       (a_perf_blocks),
        .perf_stall_cycles     (a_perf_stall),
`endif
        .m_axis_output0_tlast  (a_m_tlast)
    );

    axis_bdim_packer #(.ELEM_WIDTH(8), .BDIM(1), .NUM_BLOCKS(3)) dut1 (
        .ap_clk                (clk),
        .ap_rst_n              (rst_n),
        .s_axis_input0_tdata   (b_s_tdata),
        .s_axis_input0_tvalid  (b_s_tvalid),
        .s_axis_input0_tready  (b_s_tready),
        .m_axis_output0_tdata  (b_m_tdata),
        .m_axis_output0_tvalid (b_m_tvalid),
        .m_axis_output0_tready (b_m_tready),
`ifdef BDIM_PACKER_PERF_EN
        .perf_blocks_out       (b_perf_blocks),
        .perf_stall_cycles     (b_perf_stall),
`endif
        .m_axis_output0_tlast  (b_m_tlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] exp_blk [4];
        logic [7:0]  b_data [3];
        exp_blk[0] = 32'h44434241;
        exp_blk[1] = 32'h48474645;
        exp_blk[2] = 32'h4C4B4A49;
        exp_blk[3] = 32'h504F4E4D;
        b_data[0] = 8'h10;
        b_data[1] = 8'h20;
        b_data[2] = 8'h30;

        rst_n = 1'b0;
        a_s_tdata = 8'h00; a_s_tvalid = 1'b0; a_m_tready = 1'b0;
        b_s_tdata = 8'h00; b_s_tvalid = 1'b0; b_m_tready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        // ---- reset state ----
        chk("rst_tvalid", a_m_tvalid, 1'b0);
        chk("rst_tlast",  a_m_tlast, 1'b0);
        chk("rst_tdata",  a_m_tdata, 32'h0);
        chk("rst_tready", a_s_tready, 1'b1);
        chk("rst_b_tready", b_s_tready, 1'b1);
        chk("rst_b_tvalid", b_m_tvalid, 1'b0);

        // ---- basic frame 0x01..0x08 ----
        a_m_tready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_s_tdata = 8'(k);
            a_s_tvalid = 1'b1;
            tick();
            chk("basic_tvalid", a_m_tvalid, (k == 4 || k == 8) ? 1'b1 : 1'b0);
            if (k == 4) begin
                chk("basic_blk0", a_m_tdata, 32'h04030201);
                chk("basic_last0", a_m_tlast, 1'b0);
            end
            if (k == 8) begin
                chk("basic_blk1", a_m_tdata, 32'h08070605);
                chk("basic_last1", a_m_tlast, 1'b1);
            end
        end
        a_s_tvalid = 1'b0;
        tick();
        chk("basic_drain", a_m_tvalid, 1'b0);

        // ---- full throughput, 16 elements ----
        for (int k = 1; k <= 16; k++) begin
            a_s_tdata = 8'h40 + 8'(k);
            a_s_tvalid = 1'b1;
            #1;
            chk("full_s_tready", a_s_tready, 1'b1);
            tick();
            if (k % 4 == 0) begin
                chk("full_tvalid", a_m_tvalid, 1'b1);
                chk("full_tdata", a_m_tdata, exp_blk[k/4-1]);
                chk("full_tlast", a_m_tlast, (k % 8 == 0) ? 1'b1 : 1'b0);
            end else begin
                chk("full_gap", a_m_tvalid, 1'b0);
            end
        end
        a_s_tvalid = 1'b0;
        tick();

        // ---- backpressure ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_m_tready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            a_s_tdata = 8'(k);
            a_s_tvalid = 1'b1;
            tick();
            chk("bp_fill_tvalid", a_m_tvalid, (k == 4) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            a_s_tdata = (i < 3) ? 8'(5 + i) : 8'h08;
            a_s_tvalid = 1'b1;
            #1;
            chk("bp_s_tready", a_s_tready, (i < 3) ? 1'b1 : 1'b0);
            tick();
            chk("bp_hold_tdata", a_m_tdata, 32'h04030201);
            chk("bp_hold_tvalid", a_m_tvalid, 1'b1);
        end
        a_m_tready = 1'b1;
        #1;
        chk("bp_release_s_tready", a_s_tready, 1'b1);
        tick();
        chk("bp_next_tvalid", a_m_tvalid, 1'b1);
        chk("bp_next_tdata", a_m_tdata, 32'h08070605);
        chk("bp_next_tlast", a_m_tlast, 1'b1);
        a_s_tvalid = 1'b0;
        tick();
        chk("bp_drain", a_m_tvalid, 1'b0);
`ifdef BDIM_PACKER_PERF_EN
        chk("perf_blocks", a_perf_blocks, 32'd2);
        chk("perf_stall", a_perf_stall, 32'd10);
`endif

        // ---- reset mid-block ----
        for (int k = 0; k < 4; k++) begin
            a_s_tdata = 8'h21 + 8'(k);
            a_s_tvalid = 1'b1;
            tick();
        end
        chk("mid_pre_tdata", a_m_tdata, 32'h24232221);
        chk("mid_pre_tlast", a_m_tlast, 1'b0);
        a_s_tdata = 8'hAA;
        tick();
        a_s_tdata = 8'hBB;
        tick();
        chk("mid_partial_tvalid", a_m_tvalid, 1'b0);
        a_s_tvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_tvalid", a_m_tvalid, 1'b0);
        chk("mid_rst_tdata", a_m_tdata, 32'h0);
        for (int k = 0; k < 4; k++) begin
            a_s_tdata = 8'h11 + 8'(k);
            a_s_tvalid = 1'b1;
            tick();
            chk("mid_tvalid", a_m_tvalid, (k == 3) ? 1'b1 : 1'b0);
        end
        chk("mid_tdata", a_m_tdata, 32'h14131211);
        chk("mid_tlast", a_m_tlast, 1'b0);
        a_s_tvalid = 1'b0;
        tick();
        chk("mid_drain", a_m_tvalid, 1'b0);

        // ---- BDIM=1, NUM_BLOCKS=3 ----
        b_m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_s_tdata = b_data[k];
            b_s_tvalid = 1'b1;
            #1;
            chk("b1_s_tready", b_s_tready, 1'b1);
            tick();
            chk("b1_tvalid", b_m_tvalid, 1'b1);
            chk("b1_tdata", b_m_tdata, b_data[k]);
            chk("b1_tlast", b_m_tlast, (k == 2) ? 1'b1 : 1'b0);
        end
        b_s_tvalid = 1'b0;
        tick();
        chk("b1_drain", b_m_tvalid, 1'b0);
        b_m_tready = 1'b0;
        b_s_tdata = 8'h40;
        b_s_tvalid = 1'b1;
        tick();
        chk("b1_bp_tdata0", b_m_tdata, 8'h40);
        b_s_tdata = 8'h50;
        #1;
        chk("b1_bp_s_tready", b_s_tready, 1'b0);
        tick();
        chk("b1_bp_hold", b_m_tdata, 8'h40);
        b_m_tready = 1'b1;
        #1;
        chk("b1_bp_release", b_s_tready, 1'b1);
        tick();
        chk("b1_bp_tdata1", b_m_tdata, 8'h50);
        chk("b1_bp_tvalid1", b_m_tvalid, 1'b1);
        b_s_tvalid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_bdim_packer.md
Name: axis_bdim_packer

Overview:
- Downstream consumer of a kernel's element-serial AXI-Stream output port `m_axis_output0`.
- Collects `BDIM` consecutive elements into one packed block word and emits it on a wide AXI-Stream.
- Asserts `tlast` on the final block of each frame of `NUM_BLOCKS` blocks.
- Feeds the block-wide stream into the next kernel stage at full throughput: one element per cycle in, one block per `BDIM` cycles out.

Parameters:
- ELEM_WIDTH, 8, bits per input element.
- BDIM, 8, elements per output block; legal range 1 or more.
- NUM_BLOCKS, 4, blocks per frame; `tlast` is asserted on block `NUM_BLOCKS-1`; legal range 1 or more.

Ports:
- ap_clk  in  1  single clock; all logic on the rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- s_axis_input0_tdata  in  ELEM_WIDTH  input element.
- s_axis_input0_tvalid  in  1  input element valid.
- s_axis_input0_tready  out  1  packer can accept an element.
- m_axis_output0_tdata  out  BDIM*ELEM_WIDTH  packed block.
- m_axis_output0_tvalid  out  1  block valid.
- m_axis_output0_tready  in  1  downstream accepts the block.
- m_axis_output0_tlast  out  1  last block of the frame.

Behaviour:
- Reset and clock: one clock, `ap_clk`. Reset `ap_rst_n` is synchronous, active-low, sampled on the `ap_clk` rising edge.
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `elem_cnt`=0, `blk_cnt`=0, partial buffer cleared.
- `s_tready` is 1 from the first cycle after reset deassertion.
- Input transfer: occurs when `s_tvalid && s_tready`. Output transfer: occurs when `m_tvalid && m_tready`.
- Packing order: element k of a block (k = 0..BDIM-1, arrival order) occupies `tdata[k*ELEM_WIDTH +: ELEM_WIDTH]`. Element 0 is in the LSBs.
- Counters:
  - `elem_cnt` runs 0..BDIM-1 and wraps to 0 on the accept of the last element.
  - `blk_cnt` runs 0..NUM_BLOCKS-1 and increments when a block is loaded into the output register, wrapping to 0 after `NUM_BLOCKS-1`.
- Flow control:
  - While `elem_cnt < BDIM-1`: `s_tready`=1 unconditionally; accepted elements are written into the partial buffer.
  - While `elem_cnt == BDIM-1`: `s_tready = !m_tvalid || m_tready` (combinational from `m_tready`).
  - On accept at `elem_cnt == BDIM-1`: the output register loads the partial elements plus the current element. `m_tvalid`=1 on the next cycle. `m_tlast = (blk_cnt == NUM_BLOCKS-1)`.
- Latency: 1 cycle from accept of the last element to `m_tvalid`.
- Simultaneous load and drain: if the output transfer and the load of a new block happen in the same cycle, the new block replaces the old one and `m_tvalid` stays 1 with no bubble.
- Output stability: while `m_tvalid && !m_tready`, `m_tdata` and `m_tlast` are held stable. `m_tvalid` never deasserts without a transfer.
- Drain without load: `m_tvalid` clears on the cycle after an output transfer with no simultaneous load.
- BDIM=1: every accepted element is a block. Behaves as a 1-deep register slice with full throughput.
- Reset mid-operation: the partial block and any pending output are discarded, the frame position returns to block 0, and no output is emitted for the discarded data.
- Elaboration check: `BDIM<1` or `NUM_BLOCKS<1` causes a `$fatal` at elaboration.

Optional Feature:
- Macro: BDIM_PACKER_PERF_EN.
- When defined:
  - Adds output port `perf_blocks_out` (32 bits): count of completed output transfers.
  - Adds output port `perf_stall_cycles` (32 bits): count of cycles with `m_tvalid && !m_tready`.
  - Both counters reset to 0 on `ap_rst_n`=0 and saturate at 0xFFFFFFFF.
- When undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Basic frame, configuration ELEM_WIDTH=8, BDIM=4, NUM_BLOCKS=2, `m_tready`=1: stream 0x01..0x08 -> blocks 0x04030201 (`tlast`=0) then 0x08070605 (`tlast`=1). `m_tvalid` rises 1 cycle after each 4th accept.
- Full throughput: continuous `s_tvalid` and `m_tready`, 16 elements -> 4 blocks, output transfers exactly 4 cycles apart, `s_tready` never low, `tlast` on blocks 1 and 3.
- Backpressure: block 0x04030201 pending with `m_tready`=0 for 10 cycles, then feed 0x05..0x08.
  - 0x05..0x07 are accepted; `s_tready`=0 at the 4th element.
  - `tdata` holds 0x04030201 throughout the stall.
  - Release `m_tready` -> 0x08 is accepted in the same cycle and 0x08070605 appears next cycle with no bubble.
- Reset mid-block: accept 0xAA, 0xBB, pulse `ap_rst_n`=0 for 1 cycle, feed 0x11..0x14 -> single block 0x14131211 with `tlast`=0, and 0xAA/0xBB never appear.
- BDIM=1, NUM_BLOCKS=3: stream 0x10, 0x20, 0x30 -> 3 blocks, `tlast` only on 0x30, with 1-cycle latency each.
- With BDIM_PACKER_PERF_EN defined: run the backpressure scenario -> `perf_blocks_out`=2 and `perf_stall_cycles`=10 at its end.
